// File: rtl/zb_sync_fifo_if.sv
// Handshake bundle for zb_sync_fifo: the producer/consumer side drives through
// master, the FIFO itself connects through slave.
interface zb_sync_fifo_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_enable;
  logic                  clear_flags;

  logic [DATA_WIDTH-1:0] read_data;
  logic                  valid;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_enable, write_data, read_enable, clear_flags,
    input  read_data, valid, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  write_enable, write_data, read_enable, clear_flags,
    output read_data, valid, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/zb_sync_fifo.sv
// Parametrised single-clock FIFO with registered status flags, sticky error
// flags and a selectable first-word-fall-through read mode.
module zb_sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  zb_sync_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LIM  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_LIM = CW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         rd_ptr_next;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;
  logic                  empty_q;
  logic                  full_q;
  logic                  afull_q;
  logic                  aempty_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  valid_q;
  logic                  valid_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  ovf_set;
  logic                  unf_set;

  // A read while empty is never serviced; a write while full only goes in
  // when a read frees the slot in the same cycle.
  always_comb begin
    rd_ok       = bus.read_enable && !empty_q;
    wr_ok       = bus.write_enable && (!full_q || rd_ok);
    ovf_set     = bus.write_enable && full_q && !rd_ok;
    unf_set     = bus.read_enable && empty_q;
    rd_ptr_next = rd_ok ? rd_ptr + PW'(1) : rd_ptr;
    count_next  = count_q;
    if (wr_ok && !rd_ok) begin
      count_next = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_next = count_q - CW'(1);
    end
  end

  // In FWFT mode the output register tracks the next head; when the FIFO
  // would otherwise drain, the head is the word being written right now.
  always_comb begin
    data_next  = data_q;
    valid_next = 1'b0;
    if (FWFT) begin
      valid_next = (count_next != '0);
      if (count_next != '0) begin
        if (wr_ok && (count_q == CW'(rd_ok))) begin
          data_next = bus.write_data;
        end else begin
          data_next = mem[rd_ptr_next];
        end
      end
    end else if (rd_ok) begin
      data_next  = mem[rd_ptr];
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.write_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= (AFULL_TH == 0);
      aempty_q <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr   <= rd_ptr_next;
      count_q  <= count_next;
      empty_q  <= (count_next == '0);
      full_q   <= (count_next == FULL_COUNT);
      afull_q  <= (count_next >= AFULL_LIM);
      aempty_q <= (count_next <= AEMPTY_LIM);
      data_q   <= data_next;
      valid_q  <= valid_next;
    end
  end

  // A new error event wins over a clear arriving in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.clear_flags) begin
        ovf_q <= 1'b0;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end else if (bus.clear_flags) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign bus.read_data    = data_q;
  assign bus.valid        = valid_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  count_in_range: assert property (@(posedge clock) disable iff (!reset_n)
    count_q <= FULL_COUNT);
  empty_consistent: assert property (@(posedge clock) disable iff (!reset_n)
    empty_q == (count_q == '0));
  full_consistent: assert property (@(posedge clock) disable iff (!reset_n)
    full_q == (count_q == FULL_COUNT));
endmodule

// File: tb/tb_zb_sync_fifo.sv
// Drives one stimulus stream into a registered-read FIFO and an FWFT FIFO and
// compares both against a queue-based model of the FIFO behaviour.
module tb_zb_sync_fifo;
  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int AF0   = DEPTH - 2;
  localparam int AE0   = 2;
  localparam int AF1   = 12;
  localparam int AE1   = 0;

  logic clock;
  logic reset_n;

  zb_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  zb_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  zb_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AF0), .AEMPTY_TH(AE0), .FWFT(1'b0)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0)
  );

  zb_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AF1), .AEMPTY_TH(AE1), .FWFT(1'b1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] model_q[$];
  bit            m_ovf;
  bit            m_unf;
  logic [DW-1:0] m_data0;
  bit            m_valid0;
  logic [DW-1:0] m_data1;
  int            check_count;
  int            pass_count;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    int n;
    n = model_q.size();
    checkOutput("count0",  32'(bus0.count),        32'(n));
    checkOutput("empty0",  32'(bus0.empty),        32'(n == 0));
    checkOutput("full0",   32'(bus0.full),         32'(n == DEPTH));
    checkOutput("afull0",  32'(bus0.almost_full),  32'(n >= AF0));
    checkOutput("aempty0", 32'(bus0.almost_empty), 32'(n <= AE0));
    checkOutput("ovf0",    32'(bus0.overflow),     32'(m_ovf));
    checkOutput("unf0",    32'(bus0.underflow),    32'(m_unf));
    checkOutput("data0",   32'(bus0.read_data),    32'(m_data0));
    checkOutput("valid0",  32'(bus0.valid),        32'(m_valid0));
    checkOutput("count1",  32'(bus1.count),        32'(n));
    checkOutput("afull1",  32'(bus1.almost_full),  32'(n >= AF1));
    checkOutput("aempty1", 32'(bus1.almost_empty), 32'(n <= AE1));
    checkOutput("ovf1",    32'(bus1.overflow),     32'(m_ovf));
    checkOutput("unf1",    32'(bus1.underflow),    32'(m_unf));
    checkOutput("data1",   32'(bus1.read_data),    32'(m_data1));
    checkOutput("valid1",  32'(bus1.valid),        32'(n != 0));
  endtask

  // One clock of stimulus; the model advances from the pre-edge occupancy.
  task automatic applyStimulus(input bit we, input logic [DW-1:0] wd,
                               input bit re, input bit clr);
    bit was_empty;
    bit was_full;
    bit rd_ok;
    bit wr_ok;
    bus0.write_enable = we;  bus1.write_enable = we;
    bus0.write_data   = wd;  bus1.write_data   = wd;
    bus0.read_enable  = re;  bus1.read_enable  = re;
    bus0.clear_flags  = clr; bus1.clear_flags  = clr;
    @(posedge clock);
    was_empty = (model_q.size() == 0);
    was_full  = (model_q.size() == DEPTH);
    rd_ok     = re && !was_empty;
    wr_ok     = we && (!was_full || rd_ok);
    m_valid0  = 1'b0;
    if (rd_ok) begin
      m_data0  = model_q.pop_front();
      m_valid0 = 1'b1;
    end
    if (wr_ok) model_q.push_back(wd);
    if (we && was_full && !rd_ok) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (re && was_empty) m_unf = 1'b1;
    else if (clr) m_unf = 1'b0;
    if (model_q.size() != 0) m_data1 = model_q[0];
    #1;
    checkAll();
  endtask

  task automatic idleInputs();
    bus0.write_enable = 1'b0; bus1.write_enable = 1'b0;
    bus0.write_data   = '0;   bus1.write_data   = '0;
    bus0.read_enable  = 1'b0; bus1.read_enable  = 1'b0;
    bus0.clear_flags  = 1'b0; bus1.clear_flags  = 1'b0;
  endtask

  // Reset is asserted between edges so its asynchronous effect is visible.
  task automatic doReset();
    idleInputs();
    #2;
    reset_n = 1'b0;
    #1;
    model_q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_data0  = '0;
    m_valid0 = 1'b0;
    m_data1  = '0;
    checkAll();
    @(posedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset_n     = 1'b0;
    idleInputs();
    @(posedge clock);
    #1;
    doReset();

    $display("[TB] basic write/read");
    applyStimulus(1, 4'h1, 0, 0);
    applyStimulus(1, 4'h4, 0, 0);
    applyStimulus(1, 4'h9, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'h0, 1, 0);
    applyStimulus(0, 4'h0, 0, 0);

    $display("[TB] fill, overflow, drain");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 4'(i), 0, 0);
    applyStimulus(1, 4'h5, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 4'h0, 1, 0);
    applyStimulus(0, 4'h0, 0, 1);

    $display("[TB] underflow with concurrent write");
    applyStimulus(1, 4'h6, 1, 0);
    applyStimulus(0, 4'h0, 1, 0);
    applyStimulus(0, 4'h0, 0, 1);
    applyStimulus(0, 4'h0, 0, 0);

    $display("[TB] simultaneous read/write at full");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 4'(i + 3), 0, 0);
    applyStimulus(1, 4'hA, 1, 0);
    for (int i = 0; i < 40; i++) applyStimulus(1, 4'(i), 1, 0);
    applyStimulus(1, 4'h2, 0, 1);
    applyStimulus(1, 4'h3, 0, 1);

    $display("[TB] FWFT head tracking");
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 4'h0, 1, 0);
    applyStimulus(1, 4'h3, 0, 0);
    applyStimulus(0, 4'h0, 0, 0);
    applyStimulus(1, 4'hC, 0, 0);
    applyStimulus(0, 4'h0, 1, 0);
    applyStimulus(0, 4'h0, 1, 0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 10; i++) applyStimulus(1, 4'(i + 1), 0, 0);
    doReset();
    applyStimulus(1, 4'h7, 0, 0);
    applyStimulus(0, 4'h0, 1, 0);
    applyStimulus(0, 4'h0, 0, 0);

    $display("[TB] randomized traffic");
    for (int phase = 0; phase < 4; phase++) begin
      int wp;
      int rp;
      case (phase)
        0:       begin wp = 75; rp = 30; end
        1:       begin wp = 30; rp = 75; end
        2:       begin wp = 90; rp = 90; end
        default: begin wp = 55; rp = 50; end
      endcase
      for (int i = 0; i < 500; i++) begin
        applyStimulus($urandom_range(0, 99) < wp, 4'($urandom),
                      $urandom_range(0, 99) < rp, $urandom_range(0, 15) == 0);
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/zb_sync_fifo.md
# zb_sync_fifo

Parametrised single-clock FIFO that replaces the fixed 4-bit input and output FIFOs in the TOP transmit/receive chain (bit source → coder, CDR → output). It adds configurable width and depth, almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It is instantiated twice in TOP and remains reachable standalone through the existing debug DEMUX/MUX select paths.

## Interface
Parameters:
- DATA_WIDTH, 4, word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AFULL_TH, DEPTH-2, outAlmostFull asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, outAlmostEmpty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through

Ports (CW = $clog2(DEPTH)+1):
- inClock  in  1  single clock, all state on rising edge
- inReset  in  1  asynchronous, active-low reset
- inWriteEnable  in  1  write request
- inData  in  DATA_WIDTH  write data
- inReadEnable  in  1  read/pop request
- inClearFlags  in  1  clears sticky error flags
- outData  out  DATA_WIDTH  read data
- outValid  out  1  outData holds valid data
- outEmpty  out  1  count == 0
- outFull  out  1  count == DEPTH
- outAlmostFull  out  1  count ≥ AFULL_TH
- outAlmostEmpty  out  1  count ≤ AEMPTY_TH
- outCount  out  CW  current occupancy, 0..DEPTH
- outOverflow  out  1  sticky: a write was dropped
- outUnderflow  out  1  sticky: a read was made while empty

## Operation
- Storage: DEPTH×DATA_WIDTH array; write and read pointers are CW-1 bits wide and wrap naturally from DEPTH-1 to 0. The array is not reset.
- Read accepted (rd_ok) = inReadEnable && !outEmpty. A read while empty is never serviced, even if a write occurs in the same cycle (no write-to-read bypass).
- Write accepted (wr_ok) = inWriteEnable && (!outFull || rd_ok). When full, a simultaneous read and write are both accepted and the count is unchanged.
- Count update: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither.
- All status flags are registered and derived from the next count, so they are valid in the same cycle as outCount.
- FWFT=0: on rd_ok, the head word is registered into outData and outValid pulses high for exactly one cycle on the following cycle. Otherwise outData holds its last value and outValid = 0.
- FWFT=1: outData always shows the head entry; outValid = !outEmpty; rd_ok pops the entry and the next head appears in the following cycle.
- Overflow: inWriteEnable && outFull && !rd_ok sets outOverflow. The word is dropped and pointers are unchanged.
- Underflow: inReadEnable && outEmpty sets outUnderflow. outData is unchanged.
- inClearFlags clears both sticky flags on the next edge. If a new error event occurs in the same cycle as the clear, the set takes priority.
- Reset (inReset = 0, asynchronous): pointers = 0, outCount = 0, outEmpty = 1, outFull = 0, outAlmostEmpty = 1, outAlmostFull = (AFULL_TH == 0 ? 1 : 0), outData = 0, outValid = 0, outOverflow = 0, outUnderflow = 0. Reset mid-operation discards all contents, and the first write after deassertion lands at address 0.

## Timing
- Write-to-visible latency: a word written at edge N raises outCount and drops outEmpty after edge N. With FWFT=1 the word appears on outData after edge N. With FWFT=0 it can be read starting at edge N+1, and the data appears after that edge.
- Standard read latency (FWFT=0): 1 cycle from inReadEnable sampled to outData/outValid.
- Throughput: one write and one read per cycle sustained, at any fill level.
- Flags change only on clock edges (or on asynchronous reset) and are glitch-free registered outputs.
- Reset release must be synchronised externally to inClock. Inputs sampled in the first edge after release are honoured.

## Test plan
- Reset with DEPTH=16, DATA_WIDTH=4 → outCount=0, outEmpty=1, outAlmostEmpty=1, all other outputs 0. Then write 0x1, 0x4, 0x9 (FWFT=0) and read three times → outData sequence 0x1, 0x4, 0x9, with outValid pulsing once per read.
- Write 16 words 0x0..0xF → outFull=1 and outAlmostFull asserted from count 14. A 17th write (0x5) → outOverflow=1 and contents unchanged. Draining all 16 returns 0x0..0xF and ends with outEmpty=1.
- Read while empty, with a write of 0x6 in the same cycle → outUnderflow=1, outCount=1, outData unchanged. The next read returns 0x6. Assert inClearFlags → both sticky flags return to 0.
- At full, assert write 0xA and read together → outCount stays 16, outOverflow stays 0, and the oldest word is output. Repeat 40 cycles with incrementing data to cover pointer wrap; the read order must match the write order.
- FWFT=1: write 0x3 → outData=0x3 and outValid=1 on the next cycle with no read. A pop with 0xC queued behind it → 0xC is shown the next cycle.
- Assert reset while 10 words are stored → all outputs immediately take their reset values. After release, write 0x7 and read → 0x7 is returned.
